charlie_keyscan: RTL and testbench



---
 rtl/charlie_keyscan.sv | 167 ++++++++++++++++
 tb/tb_charlie_keyscan.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/charlie_keyscan.sv
// Charlieplexed 8x8 switch-matrix reader on the 8 bidirectional uio pins.
// One pin is driven high at a time. The other seven are sampled through external
// pull-downs, and a 64-bit key frame is assembled with bit index row*8+col, the
// same mapping the LED frame buffer uses.
//
// Optional feature: define CHARLIE_KEYSCAN_DEBOUNCE_EN to require two consecutive
// identical frames before a key bit changes in key_state. When the macro is not
// defined, key_state follows each complete frame directly.
module charlie_keyscan #(
  parameter int unsigned SETTLE_CYCLES    = 4,  // 1..255
  parameter int unsigned DISCHARGE_CYCLES = 2   // 0..255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        scan_en,
  input  logic [7:0]  uio_in,
  output logic [7:0]  uio_out,
  output logic [7:0]  uio_oe,
  output logic [63:0] key_state,
  output logic        frame_done,
  output logic        key_event
);

  localparam logic [7:0] SettleLast   = 8'(SETTLE_CYCLES - 1);
  localparam bit         HasDischarge = (DISCHARGE_CYCLES != 0);
  localparam logic [7:0] DischLast    = (DISCHARGE_CYCLES == 0) ? 8'd0
                                                                : 8'(DISCHARGE_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StDrive,
    StSample,
    StDischarge
  } state_e;

  state_e      state_q;
  logic [2:0]  row_q;
  logic [7:0]  cnt_q;
  logic [63:0] raw_next_q;
`ifdef CHARLIE_KEYSCAN_DEBOUNCE_EN
  logic [63:0] raw_prev_q;
`endif

  logic [7:0]  row_mask;
  logic [63:0] raw_sampled;
  logic [63:0] frame_raw;
  logic [63:0] key_new;
  logic        advance;
  logic        frame_end;

  // Row-select mask and the raw buffer with the current row's sample merged in.
  always_comb begin
    row_mask    = 8'h01 << row_q;
    raw_sampled = raw_next_q;
    raw_sampled[{row_q, 3'b000} +: 8] = uio_in & ~row_mask;
  end

  // Row advance happens at the end of discharge, or straight out of SAMPLE when
  // there is no discharge phase; in that case the row-7 sample must be merged in.
  always_comb begin
    advance = 1'b0;
    if (state_q == StSample && !HasDischarge) begin
      advance = 1'b1;
    end
    if (state_q == StDischarge && cnt_q == DischLast) begin
      advance = 1'b1;
    end
    frame_end = advance && (row_q == 3'd7);
    frame_raw = (state_q == StSample) ? raw_sampled : raw_next_q;
  end

  // Key frame update rule applied at frame end.
  always_comb begin
    key_new = frame_raw;
`ifdef CHARLIE_KEYSCAN_DEBOUNCE_EN
    // A bit may change only when two consecutive frames agree on it.
    key_new = (frame_raw & ~(frame_raw ^ raw_prev_q)) | (key_state & (frame_raw ^ raw_prev_q));
`endif
  end

  // Scan FSM with registered, state-decoded pin outputs and frame pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      row_q      <= 3'd0;
      cnt_q      <= 8'd0;
      raw_next_q <= 64'd0;
`ifdef CHARLIE_KEYSCAN_DEBOUNCE_EN
      raw_prev_q <= 64'd0;
`endif
      uio_out    <= 8'h00;
      uio_oe     <= 8'h00;
      key_state  <= 64'd0;
      frame_done <= 1'b0;
      key_event  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      key_event  <= 1'b0;

      if (state_q == StSample) begin
        raw_next_q <= raw_sampled;
      end

      if (frame_end) begin
        key_state  <= key_new;
        frame_done <= 1'b1;
        key_event  <= (key_new != key_state);
`ifdef CHARLIE_KEYSCAN_DEBOUNCE_EN
        raw_prev_q <= frame_raw;
`endif
        row_q      <= 3'd0;
        cnt_q      <= 8'd0;
        if (scan_en) begin
          state_q <= StDrive;
          uio_out <= 8'h01;
          uio_oe  <= 8'h01;
        end else begin
          state_q <= StIdle;
          uio_out <= 8'h00;
          uio_oe  <= 8'h00;
        end
      end else if (advance) begin
        state_q <= StDrive;
        row_q   <= row_q + 3'd1;
        cnt_q   <= 8'd0;
        uio_out <= row_mask << 1;
        uio_oe  <= row_mask << 1;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (scan_en) begin
              state_q <= StDrive;
              row_q   <= 3'd0;
              cnt_q   <= 8'd0;
              uio_out <= 8'h01;
              uio_oe  <= 8'h01;
            end
          end
          StDrive: begin
            if (cnt_q == SettleLast) begin
              state_q <= StSample;
              cnt_q   <= 8'd0;
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
          StSample: begin
            // Only reached with a discharge phase; otherwise advance handles it.
            state_q <= StDischarge;
            cnt_q   <= 8'd0;
            uio_out <= 8'h00;
            uio_oe  <= 8'hFF;
          end
          StDischarge: begin
            cnt_q <= cnt_q + 8'd1;
          end
          default: begin
            state_q <= StIdle;
            uio_out <= 8'h00;
            uio_oe  <= 8'h00;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_charlie_keyscan.sv
// Self-checking bench for charlie_keyscan: pin-level switch-matrix model, a
// frame-level reference model, a table of hand-derived frames, random frames and
// hand-written sequences for scan_en drop and mid-frame reset.
module tb_charlie_keyscan;

  localparam int Settle   = 4;
  localparam int Disch    = 2;
  localparam int RowPer   = Settle + 1 + Disch;
  localparam int FramePer = 8 * RowPer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        scan_en;
  logic [7:0]  uio_in;
  logic [7:0]  uio_out;
  logic [7:0]  uio_oe;
  logic [63:0] key_state;
  logic        frame_done;
  logic        key_event;

  charlie_keyscan #(
    .SETTLE_CYCLES   (Settle),
    .DISCHARGE_CYCLES(Disch)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .scan_en   (scan_en),
    .uio_in    (uio_in),
    .uio_out   (uio_out),
    .uio_oe    (uio_oe),
    .key_state (key_state),
    .frame_done(frame_done),
    .key_event (key_event)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Switch matrix: keys[r*8+c] closed connects pin r to pin c.
  logic [63:0] keys;
  logic [63:0] diag;

  // Reference model state.
  logic [63:0] m_ks;
  logic [63:0] m_prev;
  logic        m_ev;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int pin_index(input logic [7:0] v);
    int idx = 0;
    for (int i = 0; i < 8; i++) if (v[i]) idx = i;
    return idx;
  endfunction

  // Pin model: the driven-high pin reads itself, closed switches pull the others
  // high; anything else (idle, discharge) reads random junk that must be ignored.
  always @(negedge clk) begin
    if (uio_oe == uio_out && $onehot(uio_oe)) begin
      uio_in = keys[pin_index(uio_oe)*8 +: 8] | uio_oe;
    end else begin
      uio_in = 8'($urandom);
    end
  end

  // Electrical safety: at most one pin high, and never high and low drive together.
  always @(negedge clk) begin
    if (rst_n) begin
      check("drive_safe", {63'd0, ($countones(uio_out) <= 1) &&
            ((uio_out & ~uio_oe) == 8'h00) && (uio_out == 8'h00 || uio_oe == uio_out)}, 64'd1);
      check("diag_zero", key_state & diag, 64'd0);
    end
  end

  function automatic void model_reset();
    m_ks   = 64'd0;
    m_prev = 64'd0;
    m_ev   = 1'b0;
  endfunction

  function automatic void model_frame(input logic [63:0] fk);
    logic [63:0] raw, nk;
    raw = fk & ~diag;
`ifdef CHARLIE_KEYSCAN_DEBOUNCE_EN
    nk = m_ks;
    for (int i = 0; i < 64; i++) if (raw[i] == m_prev[i]) nk[i] = raw[i];
    m_prev = raw;
`else
    nk = raw;
`endif
    m_ev = (nk != m_ks);
    m_ks = nk;
  endfunction

  // Expected pins at cycle k of a frame that started with row 0 at k=0.
  task automatic check_pins(input int k, input bit idle);
    int p, r, ph;
    logic [7:0] eo, eu;
    p  = k % FramePer;
    r  = p / RowPer;
    ph = p % RowPer;
    if (idle) begin
      eo = 8'h00; eu = 8'h00;
    end else if (ph < Settle + 1) begin
      eo = 8'(1 << r); eu = eo;
    end else begin
      eo = 8'hFF; eu = 8'h00;
    end
    check("uio_oe", {56'd0, uio_oe}, {56'd0, eo});
    check("uio_out", {56'd0, uio_out}, {56'd0, eu});
  endtask

  // Runs one frame from just after row 0 starts; optionally drops scan_en at
  // cycle drop_k or returns early before cycle abort_k.
  task automatic do_frame(input int drop_k, input int abort_k);
    logic [63:0] fk;
    fk = keys;
    for (int k = 1; k <= FramePer; k++) begin
      if (k == abort_k) return;
      if (k == drop_k) scan_en = 1'b0;
      tick();
      check_pins(k, (k == FramePer) && !scan_en);
      if (k == FramePer) begin
        model_frame(fk);
        check("frame_done_end", {63'd0, frame_done}, 64'd1);
        check("key_state", key_state, m_ks);
        check("key_event", {63'd0, key_event}, {63'd0, m_ev});
      end else begin
        check("frame_done_mid", {63'd0, frame_done}, 64'd0);
        check("key_event_mid", {63'd0, key_event}, 64'd0);
      end
    end
  endtask

  typedef struct {
    logic [63:0] keys;
    logic [63:0] ks_plain;
    logic        ev_plain;
    logic [63:0] ks_db;
    logic        ev_db;
  } vec_t;

  localparam logic [63:0] AllD = 64'h7FBF_DFEF_F7FB_FDFE;
  localparam logic [63:0] K21  = 64'h0000_0000_0020_0000;
  localparam logic [63:0] K1   = 64'h0000_0000_0000_0002;

  vec_t tbl[11];

  initial begin
    for (int i = 0; i < 8; i++) diag[i*9] = 1'b1;
    for (int i = 0; i < 64; i++) if (i % 9 != 0) diag[i] = 1'b0;

    tbl[0]  = '{K21,         K21,  1'b1, 64'd0, 1'b0};
    tbl[1]  = '{K21,         K21,  1'b0, K21,   1'b1};
    tbl[2]  = '{64'hFFFF_FFFF_FFFF_FFFF, AllD, 1'b1, K21, 1'b0};
    tbl[3]  = '{64'hFFFF_FFFF_FFFF_FFFF, AllD, 1'b0, AllD, 1'b1};
    tbl[4]  = '{K1,          K1,   1'b1, AllD,  1'b0};
    tbl[5]  = '{64'd0,       64'd0, 1'b1, K1,   1'b1};
    tbl[6]  = '{K1,          K1,   1'b1, K1,    1'b0};
    tbl[7]  = '{64'd0,       64'd0, 1'b1, K1,   1'b0};
    tbl[8]  = '{64'd0,       64'd0, 1'b0, 64'd0, 1'b1};
    tbl[9]  = '{K1,          K1,   1'b1, 64'd0, 1'b0};
    tbl[10] = '{64'd0,       64'd0, 1'b1, 64'd0, 1'b0};

    // Reset with scan_en already high.
    rst_n   = 1'b0;
    scan_en = 1'b1;
    keys    = 64'd0;
    uio_in  = 8'h00;
    model_reset();
    repeat (3) tick();
    check("rst_oe", {56'd0, uio_oe}, 64'd0);
    check("rst_out", {56'd0, uio_out}, 64'd0);
    check("rst_ks", key_state, 64'd0);
    check("rst_fd", {63'd0, frame_done}, 64'd0);
    check("rst_ev", {63'd0, key_event}, 64'd0);

    // One IDLE cycle after release, then row 0 drive.
    rst_n = 1'b1;
    tick();
    check_pins(0, 1'b0);

    // Table-driven frames.
    for (int i = 0; i < 11; i++) begin
      keys = tbl[i].keys;
      do_frame(0, 0);
`ifdef CHARLIE_KEYSCAN_DEBOUNCE_EN
      check("tbl_ks", key_state, tbl[i].ks_db);
      check("tbl_ev", {63'd0, key_event}, {63'd0, tbl[i].ev_db});
`else
      check("tbl_ks", key_state, tbl[i].ks_plain);
      check("tbl_ev", {63'd0, key_event}, {63'd0, tbl[i].ev_plain});
`endif
    end

    // Random key patterns, each held for two frames so debounce can settle.
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) keys = {$urandom, $urandom};
      do_frame(0, 0);
    end

    // scan_en dropped during row 3: frame completes, then IDLE.
    keys = K21;
    do_frame(3 * RowPer + 2, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle_oe", {56'd0, uio_oe}, 64'd0);
      check("idle_fd", {63'd0, frame_done}, 64'd0);
    end
    scan_en = 1'b1;
    tick();
    check_pins(0, 1'b0);
    do_frame(0, 0);

    // Reset during row 5 DRIVE with a nonzero key_state.
    keys = 64'hFFFF_FFFF_FFFF_FFFF;
    do_frame(0, 0);
    do_frame(0, 0);
    check("pre_rst_nonzero", {63'd0, key_state != 64'd0}, 64'd1);
    keys = K21;
    do_frame(0, 5 * RowPer + 1);
    rst_n = 1'b0;
    tick();
    model_reset();
    check("midrst_ks", key_state, 64'd0);
    check("midrst_oe", {56'd0, uio_oe}, 64'd0);
    rst_n = 1'b1;
    tick();
    check_pins(0, 1'b0);
    do_frame(0, 0);
`ifdef CHARLIE_KEYSCAN_DEBOUNCE_EN
    check("post_rst_ks", key_state, 64'd0);
`else
    check("post_rst_ks", key_state, K21);
`endif
    do_frame(0, 0);
    check("post_rst_ks2", key_state, K21);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
